toy_tage_ctr_upd: RTL and testbench

- Read-modify-write controller for one TAGE prediction table held in the sparse table memory model.
- Sits directly upstream of that memory and drives its en/addr/wr_en/wr_data.
- Serves two request types, serialised through one FSM:
  - lookups: return the counter and taken prediction;
  - updates: apply a saturating increment or decrement.
- Unwritten entries read back as 2 (weakly taken).

---
 rtl/toy_tage_ctr_upd_pkg.sv | 30 +++
 rtl/toy_tage_ctr_upd_sat_ctr.sv | 29 ++
 rtl/toy_tage_ctr_upd.sv | 130 +++++++++++++
 tb/tb_toy_tage_ctr_upd.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_tage_ctr_upd_pkg.sv
// Shared types and helpers for the toy TAGE counter-update controller.
package toy_tage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CALC = 2'd2,
    WR   = 2'd3
  } state_t;

  typedef enum logic {
    OP_LKP = 1'b0,
    OP_UPD = 1'b1
  } op_t;

  localparam int CTR_W    = 2;
  localparam int CTR_INIT = 2;

  function automatic logic [CTR_W-1:0] sat_ctr_next(input logic [CTR_W-1:0] ctr,
                                                    input logic             taken);
    logic [CTR_W-1:0] n;
    if (taken) begin
      n = (ctr == {CTR_W{1'b1}}) ? ctr : ctr + CTR_W'(1);
    end else begin
      n = (ctr == {CTR_W{1'b0}}) ? ctr : ctr - CTR_W'(1);
    end
    return n;
  endfunction

endpackage

// File: rtl/toy_tage_ctr_upd_sat_ctr.sv
// Combinational saturating up/down step for one TAGE counter.
module toy_tage_sat_ctr
  import toy_tage_pkg::*;
#(
  parameter int CTR_WIDTH = 2
) (
  input  logic [CTR_WIDTH-1:0] ctr,
  input  logic                 taken,
  output logic [CTR_WIDTH-1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != {CTR_WIDTH{1'b1}}) begin
        ctr_nxt = ctr + CTR_WIDTH'(1);
      end else begin
        ctr_nxt = ctr;
      end
    end else begin
      if (ctr != {CTR_WIDTH{1'b0}}) begin
        ctr_nxt = ctr - CTR_WIDTH'(1);
      end else begin
        ctr_nxt = ctr;
      end
    end
  end

endmodule

// File: rtl/toy_tage_ctr_upd.sv
// Read-modify-write controller for one TAGE table: serialises lookups and counter updates.
// Optional: define TOY_TAGE_CTR_UPD_SKIP_SAT_WR_EN to skip the write of saturated updates.
module toy_tage_ctr_upd
  import toy_tage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 10,
  parameter int CTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  upd_vld,
  output logic                  upd_rdy,
  input  logic [IDX_WIDTH-1:0]  upd_idx,
  input  logic                  upd_taken,
  output logic                  upd_done,
  input  logic                  lkp_vld,
  output logic                  lkp_rdy,
  input  logic [IDX_WIDTH-1:0]  lkp_idx,
  output logic                  pred_vld,
  output logic [CTR_WIDTH-1:0]  pred_ctr,
  output logic                  pred_taken,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  state_t                state_r, state_nxt;
  op_t                   op_r, op_nxt;
  logic [IDX_WIDTH-1:0]  idx_r, idx_nxt;
  logic                  taken_r, taken_nxt;
  logic                  mem_en_nxt, mem_wr_en_nxt, upd_done_r;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wr_data_nxt;
  logic [CTR_WIDTH-1:0]  ctr_c, ctr_n;

  assign ctr_c = mem_rd_data[CTR_WIDTH-1:0];

  toy_tage_sat_ctr #(.CTR_WIDTH(CTR_WIDTH)) u_sat_ctr (
    .ctr     (ctr_c),
    .taken   (taken_r),
    .ctr_nxt (ctr_n)
  );

  // Update has fixed priority, so the lookup handshake is masked while upd_vld is high.
  assign upd_rdy    = (state_r == IDLE);
  assign lkp_rdy    = (state_r == IDLE) && !upd_vld;
  assign pred_vld   = (state_r == CALC) && (op_r == OP_LKP);
  assign pred_ctr   = pred_vld ? ctr_c : {CTR_WIDTH{1'b0}};
  assign pred_taken = pred_ctr[CTR_WIDTH-1];

`ifdef TOY_TAGE_CTR_UPD_SKIP_SAT_WR_EN
  assign upd_done = upd_done_r || ((state_r == CALC) && (op_r == OP_UPD) && (ctr_n == ctr_c));
`else
  assign upd_done = upd_done_r;
`endif

  always_comb begin
    state_nxt = state_r;
    op_nxt    = op_r;
    idx_nxt   = idx_r;
    taken_nxt = taken_r;
    case (state_r)
      IDLE: begin
        if (upd_vld) begin
          op_nxt    = OP_UPD;
          idx_nxt   = upd_idx;
          taken_nxt = upd_taken;
          state_nxt = RD;
        end else if (lkp_vld) begin
          op_nxt    = OP_LKP;
          idx_nxt   = lkp_idx;
          taken_nxt = 1'b0;
          state_nxt = RD;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD:   state_nxt = CALC;
      CALC: begin
        if (op_r == OP_LKP) begin
          state_nxt = IDLE;
        end else begin
`ifdef TOY_TAGE_CTR_UPD_SKIP_SAT_WR_EN
          state_nxt = (ctr_n == ctr_c) ? IDLE : WR;
`else
          state_nxt = WR;
`endif
        end
      end
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Memory strobes are registered from the next state so they line up with RD/WR.
    mem_en_nxt      = (state_nxt == RD) || (state_nxt == WR);
    mem_wr_en_nxt   = (state_nxt == WR);
    mem_addr_nxt    = mem_en_nxt ? ADDR_WIDTH'(idx_nxt) : {ADDR_WIDTH{1'b0}};
    mem_wr_data_nxt = mem_wr_en_nxt ? {mem_rd_data[DATA_WIDTH-1:CTR_WIDTH], ctr_n}
                                    : {DATA_WIDTH{1'b0}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= OP_LKP;
      idx_r       <= {IDX_WIDTH{1'b0}};
      taken_r     <= 1'b0;
      mem_en      <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_addr    <= {ADDR_WIDTH{1'b0}};
      mem_wr_data <= {DATA_WIDTH{1'b0}};
      upd_done_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      op_r        <= op_nxt;
      idx_r       <= idx_nxt;
      taken_r     <= taken_nxt;
      mem_en      <= mem_en_nxt;
      mem_wr_en   <= mem_wr_en_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wr_data <= mem_wr_data_nxt;
      upd_done_r  <= mem_wr_en_nxt;
    end
  end

endmodule

// File: tb/tb_toy_tage_ctr_upd.sv
// Directed scoreboard bench for toy_tage_ctr_upd with a behavioural table memory.
module tb_toy_tage_ctr_upd;
  import toy_tage_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 10;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          upd_vld, upd_rdy, upd_taken, upd_done;
  logic [IW-1:0] upd_idx, lkp_idx;
  logic          lkp_vld, lkp_rdy;
  logic          pred_vld, pred_taken;
  logic [CW-1:0] pred_ctr;
  logic          mem_en, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    int            cyc;
  } exp_t;

  exp_t          pq[$];
  exp_t          wq[$];
  logic [DW-1:0] ref_mem [0:1023];
  logic [DW-1:0] mem     [0:1023];
  logic          mem_clr, pre_en;
  logic [IW-1:0] pre_idx;
  logic [DW-1:0] pre_data;
  int            checks = 0, errors = 0, cyc = 0, done_cnt = 0, exp_done = 0;

  always #5 clk = ~clk;

  toy_tage_ctr_upd dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .upd_vld     (upd_vld),
    .upd_rdy     (upd_rdy),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .upd_done    (upd_done),
    .lkp_vld     (lkp_vld),
    .lkp_rdy     (lkp_rdy),
    .lkp_idx     (lkp_idx),
    .pred_vld    (pred_vld),
    .pred_ctr    (pred_ctr),
    .pred_taken  (pred_taken),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Table memory: read data appears the cycle after a read enable; unwritten entries hold CTR_INIT.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'(CTR_INIT);
    end else if (pre_en) begin
      mem[pre_idx] <= pre_data;
    end else if (mem_en) begin
      if (mem_wr_en) mem[mem_addr[IW-1:0]] <= mem_wr_data;
      else           mem_rd_data <= mem[mem_addr[IW-1:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (upd_done) done_cnt++;
    if (pred_vld) begin
      chk("pred_expected", {63'd0, pq.size() != 0}, 64'd1);
      if (pq.size() != 0) begin
        e = pq.pop_front();
        chk("pred_ctr", {62'd0, pred_ctr}, {62'd0, e.data[CW-1:0]});
        chk("pred_taken", {63'd0, pred_taken}, {63'd0, e.data[CW-1]});
        chk("pred_latency", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mem_wr_en) begin
      chk("write_expected", {63'd0, wq.size() != 0}, 64'd1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_data", {32'd0, mem_wr_data}, {32'd0, e.data});
        chk("wr_addr", {32'd0, mem_addr}, {32'd0, e.addr});
        chk("wr_latency", 64'(cyc), 64'(e.cyc));
        chk("wr_done_pulse", {63'd0, upd_done}, 64'd1);
        chk("wr_mem_en", {63'd0, mem_en}, 64'd1);
      end
    end
  endtask

  // Reference model: records the expected write (if any) for an update accepted now.
  task automatic push_upd(input logic [IW-1:0] idx, input logic taken);
    exp_t          e;
    int            c, n;
    logic [DW-1:0] w;
    c = int'(ref_mem[idx][CW-1:0]);
    n = taken ? c + 1 : c - 1;
    if (n > 3) n = 3;
    if (n < 0) n = 0;
    w = ref_mem[idx];
    w[CW-1:0] = n[CW-1:0];
    exp_done++;
`ifdef TOY_TAGE_CTR_UPD_SKIP_SAT_WR_EN
    if (n != c) begin
      e.data = w; e.addr = 32'(idx); e.cyc = cyc + 3;
      wq.push_back(e);
    end
`else
    e.data = w; e.addr = 32'(idx); e.cyc = cyc + 3;
    wq.push_back(e);
`endif
    ref_mem[idx] = w;
  endtask

  task automatic push_lkp(input logic [IW-1:0] idx);
    exp_t e;
    e.data = ref_mem[idx]; e.addr = 32'(idx); e.cyc = cyc + 2;
    pq.push_back(e);
  endtask

  task automatic do_upd(input logic [IW-1:0] idx, input logic taken);
    int n = 0;
    upd_vld = 1'b1; upd_idx = idx; upd_taken = taken;
    #1;
    while (!upd_rdy && n < 20) begin tick(); n++; end
    chk("upd_accept_in_time", {63'd0, n < 20}, 64'd1);
    push_upd(idx, taken);
    tick();
    upd_vld = 1'b0;
  endtask

  task automatic do_lkp(input logic [IW-1:0] idx);
    int n = 0;
    lkp_vld = 1'b1; lkp_idx = idx;
    #1;
    while (!lkp_rdy && n < 20) begin tick(); n++; end
    chk("lkp_accept_in_time", {63'd0, n < 20}, 64'd1);
    push_lkp(idx);
    tick();
    lkp_vld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((pq.size() != 0 || wq.size() != 0 || !upd_rdy) && n < 30) begin tick(); n++; end
    chk("drain_in_time", {63'd0, n < 30}, 64'd1);
  endtask

  initial begin
    int acc, d0, n;
    rst_n = 1'b0; mem_clr = 1'b1; pre_en = 1'b0; pre_idx = '0; pre_data = '0;
    upd_vld = 1'b0; upd_idx = '0; upd_taken = 1'b0; lkp_vld = 1'b0; lkp_idx = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'(CTR_INIT);
    repeat (3) tick();
    mem_clr = 1'b0;
    chk("rst_upd_rdy", {63'd0, upd_rdy}, 64'd1);
    chk("rst_lkp_rdy", {63'd0, lkp_rdy}, 64'd1);
    chk("rst_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rst_mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
    chk("rst_pred_vld", {63'd0, pred_vld}, 64'd0);
    chk("rst_upd_done", {63'd0, upd_done}, 64'd0);
    chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Unwritten entry reads back weakly taken.
    do_lkp(10'd5); drain();

    // Saturate upward, then downward.
    for (int k = 0; k < 3; k++) do_upd(10'd7, 1'b1);
    drain(); do_lkp(10'd7); drain();
    for (int k = 0; k < 3; k++) do_upd(10'd9, 1'b0);
    drain(); do_lkp(10'd9); drain();

    // Upper word bits survive the counter update.
    pre_en = 1'b1; pre_idx = 10'd4; pre_data = 32'hABCD_0001;
    tick();
    pre_en = 1'b0;
    ref_mem[4] = 32'hABCD_0001;
    d0 = done_cnt;
    do_upd(10'd4, 1'b1); drain();
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    do_lkp(10'd4); drain();

    // Simultaneous requests: update first, lookup held until IDLE returns.
    for (int k = 0; k < 2; k++) begin
      upd_vld = 1'b1; upd_idx = (k == 0) ? 10'd1 : 10'd3; upd_taken = 1'b1;
      lkp_vld = 1'b1; lkp_idx = (k == 0) ? 10'd2 : 10'd3;
      #1;
      chk("both_upd_rdy", {63'd0, upd_rdy}, 64'd1);
      chk("both_lkp_rdy", {63'd0, lkp_rdy}, 64'd0);
      push_upd(upd_idx, 1'b1);
      acc = cyc;
      tick();
      upd_vld = 1'b0;
      n = 0;
      while (!lkp_rdy && n < 20) begin tick(); n++; end
      chk("held_lkp_accept_cyc", 64'(cyc), 64'(acc + 4));
      push_lkp(lkp_idx);
      tick();
      lkp_vld = 1'b0;
      drain();
    end

    // Reset while an update sits in CALC: the write must be dropped.
    upd_vld = 1'b1; upd_idx = 10'd11; upd_taken = 1'b1;
    #1;
    chk("rstcalc_accept", {63'd0, upd_rdy}, 64'd1);
    tick();
    upd_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstcalc_mem_en", {63'd0, mem_en}, 64'd0);
    chk("rstcalc_mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
    chk("rstcalc_upd_done", {63'd0, upd_done}, 64'd0);
    chk("rstcalc_upd_rdy", {63'd0, upd_rdy}, 64'd1);
    chk("rstcalc_lkp_rdy", {63'd0, lkp_rdy}, 64'd1);
    chk("rstcalc_wr_data", {32'd0, mem_wr_data}, 64'd0);
    repeat (4) tick();
    do_lkp(10'd11); drain();

    chk("done_total", 64'(done_cnt), 64'(exp_done));
    chk("pred_queue_empty", 64'(pq.size()), 64'd0);
    chk("write_queue_empty", 64'(wq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
